// File: rtl/pe_row_sparse_drain_if.sv
// Sparse-feature row bus: weight load port, non-zero beat stream and drain stream.
// master = feature/weight source and drain sink; slave = the PE row.
interface pe_row_sparse_drain_if #(
    parameter int unsigned PE_DIM     = 16,
    parameter int unsigned FEAT_WIDTH = 8,
    parameter int unsigned WGT_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned SPAD_DEPTH = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(SPAD_DEPTH),
    parameter int unsigned COL_WIDTH  = $clog2(PE_DIM)
);
    logic                  w_we;
    logic [COL_WIDTH-1:0]  w_col;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [WGT_WIDTH-1:0]  w_data;

    logic                  nz_valid;
    logic                  nz_ready;
    logic [ADDR_WIDTH-1:0] nz_addr;
    logic [FEAT_WIDTH-1:0] nz_data;
    logic                  nz_last;
    logic                  acc_keep;

    logic                  out_valid;
    logic                  out_ready;
    logic [COL_WIDTH-1:0]  out_col;
    logic [ACC_WIDTH-1:0]  out_data;
    logic                  out_last;

    modport master (
        output w_we, w_col, w_addr, w_data,
        output nz_valid, nz_addr, nz_data, nz_last, acc_keep,
        input  nz_ready,
        input  out_valid, out_col, out_data, out_last,
        output out_ready
    );

    modport slave (
        input  w_we, w_col, w_addr, w_data,
        input  nz_valid, nz_addr, nz_data, nz_last, acc_keep,
        output nz_ready,
        output out_valid, out_col, out_data, out_last,
        input  out_ready
    );
endinterface

// File: rtl/pe_row_sparse_drain.sv
// GNN PE row: broadcast sparse features, per-column weight lookup and saturating
// accumulate, then either hold partial sums or drain one column per beat.
module pe_row_sparse_drain #(
    parameter int unsigned PE_DIM     = 16,
    parameter int unsigned FEAT_WIDTH = 8,
    parameter int unsigned WGT_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned SPAD_DEPTH = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(SPAD_DEPTH),
    parameter int unsigned COL_WIDTH  = $clog2(PE_DIM)
) (
    input  logic                        clk,
    input  logic                        reset,
    pe_row_sparse_drain_if.slave        bus,
    output logic                        sat_flag,
    output logic                        busy
);
    localparam int unsigned PROD_WIDTH = FEAT_WIDTH + WGT_WIDTH;
    localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(PE_DIM - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StAccum, StFlush, StDrain} state_e;

    state_e                       state_q;
    logic [WGT_WIDTH-1:0]         spad_q [PE_DIM][SPAD_DEPTH];
    logic signed [PROD_WIDTH-1:0] prod_q [PE_DIM];
    logic                         prod_vld_q;
    logic signed [ACC_WIDTH-1:0]  acc_q  [PE_DIM];
    logic signed [ACC_WIDTH-1:0]  acc_d  [PE_DIM];
    logic signed [ACC_WIDTH:0]    sum    [PE_DIM];
    logic                         sat_any;
    logic                         sat_q;
    logic                         out_valid_q;
    logic [COL_WIDTH-1:0]         out_col_q;
    logic [COL_WIDTH-1:0]         col_nxt;
    logic [ACC_WIDTH-1:0]         out_data_q;
    logic                         out_last_q;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic                         nz_hs;
    logic                         out_hs;

    assign bus.nz_ready  = (state_q == StAccum) && !reset;
    assign nz_hs         = bus.nz_valid && bus.nz_ready;
    assign out_hs        = out_valid_q && bus.out_ready;
    assign rd_addr       = bus.nz_addr;
    assign col_nxt       = out_col_q + 1'b1;

    assign bus.out_valid = out_valid_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign sat_flag      = sat_q;
    assign busy          = (state_q != StAccum);

    // Scratchpads and the product stage carry no reset; reads see pre-edge contents,
    // so a same-cycle write to the read entry yields the old weight.
    always_ff @(posedge clk) begin
        if (bus.w_we) begin
            for (int c = 0; c < PE_DIM; c++) begin
                if (bus.w_col == COL_WIDTH'(c)) spad_q[c][bus.w_addr] <= bus.w_data;
            end
        end
        if (nz_hs) begin
            for (int c = 0; c < PE_DIM; c++) begin
                prod_q[c] <= PROD_WIDTH'($signed(bus.nz_data)) *
                             PROD_WIDTH'($signed(spad_q[c][rd_addr]));
            end
        end
    end

    // One guard bit on the sum detects overflow in either direction.
    always_comb begin
        sat_any = 1'b0;
        for (int c = 0; c < PE_DIM; c++) begin
            sum[c]   = (ACC_WIDTH+1)'(acc_q[c]) + (ACC_WIDTH+1)'(prod_q[c]);
            acc_d[c] = acc_q[c];
            if (prod_vld_q) begin
                if (sum[c][ACC_WIDTH] != sum[c][ACC_WIDTH-1]) begin
                    acc_d[c] = sum[c][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                    sat_any  = 1'b1;
                end else begin
                    acc_d[c] = sum[c][ACC_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StAccum;
            prod_vld_q  <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            for (int c = 0; c < PE_DIM; c++) acc_q[c] <= '0;
        end else begin
            prod_vld_q <= nz_hs;
            sat_q      <= sat_q | sat_any;
            for (int c = 0; c < PE_DIM; c++) acc_q[c] <= acc_d[c];
            unique case (state_q)
                StAccum: begin
                    if (nz_hs && bus.nz_last && !bus.acc_keep) state_q <= StFlush;
                end
                StFlush: begin
                    // Last product lands this edge, so column 0 is taken from acc_d.
                    state_q     <= StDrain;
                    out_valid_q <= 1'b1;
                    out_col_q   <= '0;
                    out_data_q  <= acc_d[0];
                    out_last_q  <= (PE_DIM == 1);
                end
                StDrain: begin
                    if (out_hs) begin
                        if (out_last_q) begin
                            state_q     <= StAccum;
                            sat_q       <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_col_q   <= '0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                            for (int c = 0; c < PE_DIM; c++) acc_q[c] <= '0;
                        end else begin
                            out_col_q  <= col_nxt;
                            out_data_q <= acc_q[col_nxt];
                            out_last_q <= (col_nxt == LAST_COL);
                        end
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_row_sparse_drain.sv
// Self-checking bench for pe_row_sparse_drain: directed scenarios plus randomized
// vectors scored against an arithmetic model of weights and clamped sums.
module tb_pe_row_sparse_drain;
    localparam int PE_DIM     = 16;
    localparam int FEAT_WIDTH = 8;
    localparam int WGT_WIDTH  = 8;
    localparam int ACC_WIDTH  = 24;
    localparam int SPAD_DEPTH = 64;
    localparam int COL_WIDTH  = 4;
    localparam int ADDR_WIDTH = 6;
    localparam longint ACC_MAX = (longint'(1) << (ACC_WIDTH - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) << (ACC_WIDTH - 1));

    logic clk = 1'b0;
    logic reset;
    logic sat_flag;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    int     w_m   [PE_DIM][SPAD_DEPTH];
    longint acc_m [PE_DIM];
    bit     sat_m;

    pe_row_sparse_drain_if bus ();

    pe_row_sparse_drain dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sat_flag (sat_flag),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic void model_beat(input int addr, input int data);
        for (int c = 0; c < PE_DIM; c++) begin
            acc_m[c] = acc_m[c] + longint'(data) * longint'(w_m[c][addr]);
            if (acc_m[c] > ACC_MAX) begin acc_m[c] = ACC_MAX; sat_m = 1'b1; end
            if (acc_m[c] < ACC_MIN) begin acc_m[c] = ACC_MIN; sat_m = 1'b1; end
        end
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < PE_DIM; c++) acc_m[c] = 0;
        sat_m = 1'b0;
    endfunction

    task automatic write_w(input int col, input int addr, input int data);
        @(negedge clk);
        bus.w_we   = 1'b1;
        bus.w_col  = COL_WIDTH'(col);
        bus.w_addr = ADDR_WIDTH'(addr);
        bus.w_data = WGT_WIDTH'(data);
        @(posedge clk);
        #1 bus.w_we = 1'b0;
        w_m[col][addr] = data;
    endtask

    task automatic send_beat(input int addr, input int data, input bit last, input bit keep);
        int guard = 0;
        @(negedge clk);
        while (bus.nz_ready !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
        if (bus.nz_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL nz_ready_timeout nz_ready=%b required 1", bus.nz_ready);
        end
        bus.nz_valid = 1'b1;
        bus.nz_addr  = ADDR_WIDTH'(addr);
        bus.nz_data  = FEAT_WIDTH'(data);
        bus.nz_last  = last;
        bus.acc_keep = keep;
        @(posedge clk);
        #1 bus.nz_valid = 1'b0;
        model_beat(addr, data);
    endtask

    task automatic drain_check(input string name, input int stall_col, input int stall_len,
                               input bit rand_stall);
        int guard;
        int slen;
        logic [ACC_WIDTH-1:0] exp_d;
        for (int k = 0; k < PE_DIM; k++) begin
            @(negedge clk);
            guard = 0;
            while (bus.out_valid !== 1'b1 && guard < 8) begin @(negedge clk); guard++; end
            n_checks++;
            if (bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s drain_timeout k=%0d out_valid=%b required 1", name, k,
                         bus.out_valid);
                return;
            end
            exp_d = ACC_WIDTH'(acc_m[k]);
            n_checks++;
            if (bus.out_col !== COL_WIDTH'(k)) begin
                n_fail++;
                $display("FAIL %s out_col got %0d required %0d", name, bus.out_col, k);
            end
            n_checks++;
            if (bus.out_data !== exp_d) begin
                n_fail++;
                $display("FAIL %s out_data col %0d got %0d required %0d", name, k,
                         $signed(bus.out_data), $signed(exp_d));
            end
            n_checks++;
            if (bus.out_last !== (k == PE_DIM - 1)) begin
                n_fail++;
                $display("FAIL %s out_last col %0d got %b", name, k, bus.out_last);
            end
            n_checks++;
            if (sat_flag !== sat_m) begin
                n_fail++;
                $display("FAIL %s sat_flag col %0d got %b required %b", name, k, sat_flag, sat_m);
            end
            slen = (k == stall_col) ? stall_len :
                   ((rand_stall && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
            if (slen > 0) begin
                bus.out_ready = 1'b0;
                repeat (slen) begin
                    @(negedge clk);
                    n_checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_col !== COL_WIDTH'(k) ||
                        bus.out_data !== exp_d) begin
                        n_fail++;
                        $display("FAIL %s stall_stable got v=%b col=%0d data=%0d required 1/%0d/%0d",
                                 name, bus.out_valid, bus.out_col, $signed(bus.out_data), k,
                                 $signed(exp_d));
                    end
                end
                bus.out_ready = 1'b1;
            end
            @(posedge clk);
        end
        model_clear();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.nz_ready !== 1'b1 || busy !== 1'b0 || sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_drain got v=%b rdy=%b busy=%b sat=%b required 0/1/0/0", name,
                     bus.out_valid, bus.nz_ready, busy, sat_flag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.nz_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_nz_ready got %b required 0", bus.nz_ready);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_col !== '0 || bus.out_data !== '0 ||
            bus.out_last !== 1'b0 || sat_flag !== 1'b0 || busy !== 1'b0 || bus.nz_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values got v=%b col=%0d data=%0d last=%b sat=%b busy=%b rdy=%b",
                     bus.out_valid, bus.out_col, bus.out_data, bus.out_last, sat_flag, busy,
                     bus.nz_ready);
        end
        model_clear();
    endtask

    task automatic test_single_drain();
        for (int c = 0; c < PE_DIM; c++) write_w(c, 3, c + 1);
        send_beat(3, 2, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.nz_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state got busy=%b v=%b rdy=%b required 1/0/0", busy,
                     bus.out_valid, bus.nz_ready);
        end
        drain_check("single", -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        send_beat(3, 2, 1'b1, 1'b0);
        drain_check("stall", 4, 5, 1'b0);
    endtask

    task automatic test_keep();
        for (int c = 0; c < PE_DIM; c++) write_w(c, 0, 5);
        send_beat(0, 3, 1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (bus.nz_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL keep_hold got rdy=%b busy=%b v=%b required 1/0/0", bus.nz_ready,
                         busy, bus.out_valid);
            end
        end
        send_beat(0, 3, 1'b1, 1'b0);
        drain_check("keep", -1, 0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int c = 0; c < PE_DIM; c++) write_w(c, 1, 127);
        for (int i = 0; i < 600; i++) send_beat(1, 127, i == 599, 1'b0);
        @(negedge clk);
        n_checks++;
        if (sat_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos_flag got %b required 1", sat_flag);
        end
        drain_check("sat_pos", -1, 0, 1'b0);
        send_beat(3, 2, 1'b1, 1'b0);
        drain_check("sat_clear", -1, 0, 1'b0);
        for (int i = 0; i < 600; i++) send_beat(1, -128, i == 599, 1'b0);
        drain_check("sat_neg", -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        int guard = 0;
        send_beat(3, 5, 1'b1, 1'b0);
        @(negedge clk);
        while (!(bus.out_valid === 1'b1 && bus.out_col === 4'd7) && guard < 40) begin
            @(negedge clk); guard++;
        end
        n_checks++;
        if (bus.out_col !== 4'd7) begin
            n_fail++;
            $display("FAIL reset_mid_reach got col=%0d required 7", bus.out_col);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.nz_ready !== 1'b1 ||
            bus.out_col !== '0 || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got v=%b busy=%b rdy=%b col=%0d data=%0d required 0/0/1/0/0",
                     bus.out_valid, busy, bus.nz_ready, bus.out_col, bus.out_data);
        end
        send_beat(3, 1, 1'b1, 1'b0);
        drain_check("after_reset", -1, 0, 1'b0);
    endtask

    task automatic test_read_before_write();
        for (int c = 0; c < PE_DIM; c++) write_w(c, 2, (c == 0) ? 4 : c + 2);
        @(negedge clk);
        bus.w_we     = 1'b1;
        bus.w_col    = '0;
        bus.w_addr   = 6'd2;
        bus.w_data   = 8'd9;
        bus.nz_valid = 1'b1;
        bus.nz_addr  = 6'd2;
        bus.nz_data  = 8'd1;
        bus.nz_last  = 1'b1;
        bus.acc_keep = 1'b0;
        @(posedge clk);
        #1;
        bus.w_we     = 1'b0;
        bus.nz_valid = 1'b0;
        model_beat(2, 1);
        w_m[0][2] = 9;
        drain_check("rbw_old", -1, 0, 1'b0);
        send_beat(2, 1, 1'b1, 1'b0);
        drain_check("rbw_new", -1, 0, 1'b0);
    endtask

    task automatic test_random();
        int len;
        bit keep;
        for (int c = 0; c < PE_DIM; c++)
            for (int a = 8; a < 16; a++) write_w(c, a, int'($urandom_range(0, 255)) - 128);
        for (int v = 0; v < 25; v++) begin
            if ($urandom_range(0, 1) == 1)
                write_w(int'($urandom_range(0, PE_DIM - 1)), int'($urandom_range(8, 15)),
                        int'($urandom_range(0, 255)) - 128);
            len  = int'($urandom_range(1, 20));
            keep = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < len; i++)
                send_beat(int'($urandom_range(8, 15)), int'($urandom_range(0, 255)) - 128,
                          i == len - 1, keep);
            if (!keep) drain_check("random", -1, 0, 1'b1);
        end
        send_beat(8, 1, 1'b1, 1'b0);
        drain_check("random_tail", -1, 0, 1'b1);
    endtask

    initial begin
        reset         = 1'b1;
        bus.w_we      = 1'b0;
        bus.w_col     = '0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        bus.nz_valid  = 1'b0;
        bus.nz_addr   = '0;
        bus.nz_data   = '0;
        bus.nz_last   = 1'b0;
        bus.acc_keep  = 1'b0;
        bus.out_ready = 1'b1;
        model_clear();
        test_reset();
        for (int c = 0; c < PE_DIM; c++)
            for (int a = 0; a < SPAD_DEPTH; a++) write_w(c, a, 0);
        test_single_drain();
        test_backpressure();
        test_keep();
        test_saturation();
        test_reset_mid_drain();
        test_read_before_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
